ecc_scrub_ctrl: RTL and testbench
=================================

Name: ecc_scrub_ctrl

Overview:
Background scrubber for a SECDED-protected memory built on hamming_enc/hamming_dec. Walks every address and issues a read; the decoder result returns through the memory path. On a single-bit error it writes the corrected word back, which re-encodes it on write. Counts correctable and uncorrectable errors and reports the last uncorrectable address. Host traffic wins the memory port through the external grant.

Parameters:
K, 8, data width of the protected word (matches hamming_enc/hamming_dec K)
DEPTH, 256, number of memory words scrubbed per pass
AW, $clog2(DEPTH), address width
INTERVAL, 1024, idle cycles between successive read accesses (throttle), >=1
CW, 16, width of the error counters

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
scrub_en_i  in  1  level enable; deasserting finishes the current access, then returns to IDLE
mem_req_o  out  1  memory access request, held until granted
mem_we_o  out  1  1 = write-back, 0 = read; valid with mem_req_o
mem_addr_o  out  AW  access address
mem_wdata_o  out  K  corrected data for write-back (goes to the encoder)
mem_gnt_i  in  1  grant; a transfer occurs on a cycle with req&gnt
mem_rvalid_i  in  1  decoded read result valid (arbitrary latency >=1 after grant)
dec_data_i  in  K  corrected data from the decoder
dec_sb_err_i  in  1  decoder single-bit-error flag, qualified by rvalid
dec_db_err_i  in  1  decoder double-bit-error flag, qualified by rvalid
sb_cnt_o  out  CW  saturating count of corrected errors
db_cnt_o  out  CW  saturating count of uncorrectable errors
db_addr_o  out  AW  address of the most recent uncorrectable error
db_irq_o  out  1  one-cycle pulse per uncorrectable error
pass_done_o  out  1  one-cycle pulse when address DEPTH-1 completes
busy_o  out  1  high in any state except IDLE

Behaviour:
- Reset: state IDLE, address 0, all outputs 0, interval counter 0.
- States: IDLE, WAIT, RD_REQ, RD_WAIT, WR_REQ, ADV.
- IDLE -> WAIT when scrub_en_i=1. Interval counter loads INTERVAL-1.
- WAIT: counter decrements. At 0 -> RD_REQ. If scrub_en_i=0 -> IDLE.
- RD_REQ: mem_req_o=1, mem_we_o=0, mem_addr_o=addr. Held until mem_gnt_i, then -> RD_WAIT. Req/addr stay stable while ungranted.
- RD_WAIT: wait for mem_rvalid_i; no timeout.
  - db_err=1 (takes priority over sb_err): db_cnt++, db_addr_o<=addr, db_irq_o pulse next cycle, no write-back, -> ADV.
  - sb_err=1 only: sb_cnt++, latch dec_data_i into mem_wdata_o, -> WR_REQ.
  - Clean: -> ADV.
- WR_REQ: mem_req_o=1, mem_we_o=1, same addr; held until grant -> ADV.
- ADV: if addr==DEPTH-1, addr<=0 and pass_done_o pulses; otherwise addr++. Then -> WAIT if scrub_en_i=1, else IDLE.
- scrub_en_i is sampled only in IDLE, WAIT and ADV. An in-flight read, or a write-back it triggers, always completes.
- rvalid outside RD_WAIT is ignored (it belongs to the host).
- Counters saturate at 2^CW-1 and never wrap.
- Latency for a clean word at zero grant/read latency: INTERVAL + 3 cycles per address.
- rst_i mid-access drops mem_req_o next cycle and clears counters and address.

Optional Feature:
ECC_SCRUB_HALT_ON_DB_EN
- Defined: a double-bit error sends the FSM to a HALT state after the counter update. busy_o stays 1 and no requests issue. Exit to IDLE only when scrub_en_i=0; the address stays at the failing word.
- Undefined: no HALT state; scrubbing continues as described above.

Decomposition:
- Package ecc_pkg: calculate_m function, scrub state enum typedef, shared K default.
- Sub-module sat_counter (width CW, inc, clear): instantiated twice, for sb_cnt_o and db_cnt_o.

Test Plan:
- DEPTH=4, INTERVAL=2, gnt tied 1, rvalid 1 cycle after grant, all clean -> 4 reads at addr 0..3, no writes, pass_done_o pulses once, counters 0.
- sb_err=1 with dec_data_i=8'hA5 at addr 2 -> write request at addr 2 with wdata 8'hA5, sb_cnt_o=1, then addr 3 read.
- db_err=1 and sb_err=1 together at addr 1 -> no write, db_cnt_o=1, db_addr_o=1, db_irq_o one cycle wide.
- gnt held 0 for 10 cycles during RD_REQ -> mem_req_o/addr stable the whole time, single transfer once gnt=1.
- scrub_en_i dropped in RD_WAIT, sb_err returned -> write-back still issued, then IDLE, busy_o=0.
- CW=2, five sb errors -> sb_cnt_o saturates at 3.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared types and helpers for the SECDED scrub controller.
// Optional HALT state is present only when ECC_SCRUB_HALT_ON_DB_EN is defined.
package ecc_pkg;

   localparam int unsigned ECC_K = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_RD_REQ,
      S_RD_WAIT,
      S_WR_REQ,
`ifdef ECC_SCRUB_HALT_ON_DB_EN
      S_ADV,
      S_HALT
`else
      S_ADV
`endif
   } scrub_state_e;

   // Number of Hamming parity bits for k data bits: smallest m with 2^m >= k+m+1.
   function automatic int unsigned calculate_m(input int unsigned k);
      int unsigned m;
      m = 1;
      for (int i = 0; i < 32; i++) begin
         if ((32'd1 << m) < (k + m + 1)) m = m + 1;
      end
      return m;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         i_clk,
   input  logic         i_clr,
   input  logic         i_inc,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_clr)                             r_cnt <= '0;
      else if (i_inc && (r_cnt != {W{1'b1}})) r_cnt <= r_cnt + W'(1);
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Background scrubber: throttled read of every word, write-back of corrected data, error stats.
// Define ECC_SCRUB_HALT_ON_DB_EN to park in HALT after an uncorrectable error.
module ecc_scrub_ctrl
   import ecc_pkg::*;
#(
   parameter int unsigned K        = ECC_K,
   parameter int unsigned DEPTH    = 256,
   parameter int unsigned AW       = $clog2(DEPTH),
   parameter int unsigned INTERVAL = 1024,
   parameter int unsigned CW       = 16
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          scrub_en_i,
   output logic          mem_req_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [K-1:0]  mem_wdata_o,
   input  logic          mem_gnt_i,
   input  logic          mem_rvalid_i,
   input  logic [K-1:0]  dec_data_i,
   input  logic          dec_sb_err_i,
   input  logic          dec_db_err_i,
   output logic [CW-1:0] sb_cnt_o,
   output logic [CW-1:0] db_cnt_o,
   output logic [AW-1:0] db_addr_o,
   output logic          db_irq_o,
   output logic          pass_done_o,
   output logic          busy_o
);

   localparam int unsigned   IW        = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
   localparam logic [IW-1:0] LP_RELOAD = IW'(INTERVAL - 1);
   localparam logic [AW-1:0] LP_LAST   = AW'(DEPTH - 1);

   scrub_state_e r_state, w_state_nxt;
   logic [IW-1:0] r_cnt, w_cnt_nxt;
   logic [AW-1:0] r_addr, w_addr_nxt;
   logic [K-1:0]  r_wdata, w_wdata_nxt;
   logic [AW-1:0] r_db_addr;
   logic          r_req, r_we, r_busy, r_db_irq, r_pass;
   logic          w_sb_inc, w_db_hit, w_pass;

   // Next-state and datapath decisions
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_addr_nxt  = r_addr;
      w_wdata_nxt = r_wdata;
      w_sb_inc    = 1'b0;
      w_db_hit    = 1'b0;
      w_pass      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (scrub_en_i) begin
               w_state_nxt = S_WAIT;
               w_cnt_nxt   = LP_RELOAD;
            end
         end
         S_WAIT: begin
            if (!scrub_en_i)       w_state_nxt = S_IDLE;
            else if (r_cnt == '0)  w_state_nxt = S_RD_REQ;
            else                   w_cnt_nxt   = r_cnt - IW'(1);
         end
         S_RD_REQ: begin
            if (mem_gnt_i) w_state_nxt = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (mem_rvalid_i) begin
               if (dec_db_err_i) begin
                  w_db_hit = 1'b1;
`ifdef ECC_SCRUB_HALT_ON_DB_EN
                  w_state_nxt = S_HALT;
`else
                  w_state_nxt = S_ADV;
`endif
               end else if (dec_sb_err_i) begin
                  w_sb_inc    = 1'b1;
                  w_wdata_nxt = dec_data_i;
                  w_state_nxt = S_WR_REQ;
               end else begin
                  w_state_nxt = S_ADV;
               end
            end
         end
         S_WR_REQ: begin
            if (mem_gnt_i) w_state_nxt = S_ADV;
         end
         S_ADV: begin
            if (r_addr == LP_LAST) begin
               w_addr_nxt = '0;
               w_pass     = 1'b1;
            end else begin
               w_addr_nxt = r_addr + AW'(1);
            end
            if (scrub_en_i) begin
               w_state_nxt = S_WAIT;
               w_cnt_nxt   = LP_RELOAD;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
`ifdef ECC_SCRUB_HALT_ON_DB_EN
         S_HALT: begin
            if (!scrub_en_i) w_state_nxt = S_IDLE;
         end
`endif
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State and registered outputs, decoded from the next state
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_db_addr <= '0;
         r_req     <= 1'b0;
         r_we      <= 1'b0;
         r_busy    <= 1'b0;
         r_db_irq  <= 1'b0;
         r_pass    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_addr   <= w_addr_nxt;
         r_wdata  <= w_wdata_nxt;
         r_req    <= (w_state_nxt == S_RD_REQ) || (w_state_nxt == S_WR_REQ);
         r_we     <= (w_state_nxt == S_WR_REQ);
         r_busy   <= (w_state_nxt != S_IDLE);
         r_db_irq <= w_db_hit;
         r_pass   <= w_pass;
         if (w_db_hit) r_db_addr <= r_addr;
      end
   end

   sat_counter #(.W(CW)) u_sb_cnt (
      .i_clk (clk_i),
      .i_clr (rst_i),
      .i_inc (w_sb_inc),
      .o_cnt (sb_cnt_o)
   );

   sat_counter #(.W(CW)) u_db_cnt (
      .i_clk (clk_i),
      .i_clr (rst_i),
      .i_inc (w_db_hit),
      .o_cnt (db_cnt_o)
   );

   assign mem_req_o   = r_req;
   assign mem_we_o    = r_we;
   assign mem_addr_o  = r_addr;
   assign mem_wdata_o = r_wdata;
   assign db_addr_o   = r_db_addr;
   assign db_irq_o    = r_db_irq;
   assign pass_done_o = r_pass;
   assign busy_o      = r_busy;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Directed bench for ecc_scrub_ctrl: scoreboard of expected memory transfers plus status checks.
module tb_ecc_scrub_ctrl;

   localparam int unsigned K        = 8;
   localparam int unsigned DEPTH    = 4;
   localparam int unsigned AW       = 2;
   localparam int unsigned INTERVAL = 2;
   localparam int unsigned CW       = 2;

   logic          clk = 1'b0;
   logic          rst, en, gnt, rvalid, sb, db;
   logic          req, we, irq, pass, busy;
   logic [AW-1:0] addr, db_addr;
   logic [K-1:0]  wdata, dec_data;
   logic [CW-1:0] sb_cnt, db_cnt;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [K-1:0]  wdata;
   } xfer_t;

   xfer_t         exp_q[$];
   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;
   int            pass_cycles = 0;
   int            irq_cycles = 0;
   int            rd_cyc[DEPTH];
   int            inj_sb[DEPTH];
   int            inj_db[DEPTH];
   logic [K-1:0]  inj_data[DEPTH];
   logic          pend = 1'b0;
   logic [AW-1:0] pend_addr = '0;

   always #5 clk = ~clk;

   ecc_scrub_ctrl #(.K(K), .DEPTH(DEPTH), .INTERVAL(INTERVAL), .CW(CW)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .scrub_en_i   (en),
      .mem_req_o    (req),
      .mem_we_o     (we),
      .mem_addr_o   (addr),
      .mem_wdata_o  (wdata),
      .mem_gnt_i    (gnt),
      .mem_rvalid_i (rvalid),
      .dec_data_i   (dec_data),
      .dec_sb_err_i (sb),
      .dec_db_err_i (db),
      .sb_cnt_o     (sb_cnt),
      .db_cnt_o     (db_cnt),
      .db_addr_o    (db_addr),
      .db_irq_o     (irq),
      .pass_done_o  (pass),
      .busy_o       (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic push_rd(input int a);
      exp_q.push_back('{we: 1'b0, addr: AW'(a), wdata: '0});
   endtask

   task automatic push_wr(input int a, input logic [K-1:0] d);
      exp_q.push_back('{we: 1'b1, addr: AW'(a), wdata: d});
   endtask

   task automatic wait_pass();
      bit seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (pass) seen = 1;
      end
      chk("pass_done_seen", 32'(seen), 32'd1);
   endtask

   task automatic wait_idle();
      bit seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (!busy) seen = 1;
      end
      chk("idle_reached", 32'(seen), 32'd1);
   endtask

   task automatic wait_req();
      bit seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (req) seen = 1;
      end
      chk("req_seen", 32'(seen), 32'd1);
   endtask

   always @(posedge clk) cyc++;

   // Memory model: decoded read data one cycle after a read grant; transfer scoreboard
   always @(negedge clk) begin
      #1;
      rvalid = 1'b0;
      sb     = 1'b0;
      db     = 1'b0;
      if (pend) begin
         rvalid   = 1'b1;
         dec_data = 8'h30 | {6'd0, pend_addr};
         if (inj_sb[pend_addr] > 0 || inj_db[pend_addr] > 0) dec_data = inj_data[pend_addr];
         if (inj_sb[pend_addr] > 0) begin sb = 1'b1; inj_sb[pend_addr]--; end
         if (inj_db[pend_addr] > 0) begin db = 1'b1; inj_db[pend_addr]--; end
         pend = 1'b0;
      end
      if (!rst && req && gnt) begin
         chk("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            xfer_t e;
            e = exp_q.pop_front();
            chk("xfer_we", 32'(we), 32'(e.we));
            chk("xfer_addr", 32'(addr), 32'(e.addr));
            if (e.we) chk("xfer_wdata", 32'(wdata), 32'(e.wdata));
         end
         if (!we) begin
            pend      = 1'b1;
            pend_addr = addr;
            rd_cyc[addr] = cyc;
         end
      end
      if (pass) pass_cycles++;
      if (irq)  irq_cycles++;
   end

   initial begin
      rst = 1'b1; en = 1'b0; gnt = 1'b1;
      rvalid = 1'b0; sb = 1'b0; db = 1'b0; dec_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         inj_sb[i] = 0; inj_db[i] = 0; inj_data[i] = '0; rd_cyc[i] = 0;
      end
      repeat (3) @(negedge clk);
      chk("rst_req", 32'(req), 32'd0);
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_addr", 32'(addr), 32'd0);
      chk("rst_sb_cnt", 32'(sb_cnt), 32'd0);
      chk("rst_db_cnt", 32'(db_cnt), 32'd0);
      chk("rst_db_addr", 32'(db_addr), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_pass", 32'(pass), 32'd0);
      rst = 1'b0;

      // Clean pass over all four words
      for (int a = 0; a < DEPTH; a++) push_rd(a);
      @(negedge clk);
      en = 1'b1;
      wait_pass();
      en = 1'b0;
      wait_idle();
      chk("clean_q_empty", 32'(exp_q.size()), 32'd0);
      chk("clean_pass_width", 32'(pass_cycles), 32'd1);
      chk("clean_rd_gap", 32'(rd_cyc[1] - rd_cyc[0]), 32'(INTERVAL + 3));
      chk("clean_sb_cnt", 32'(sb_cnt), 32'd0);
      chk("clean_db_cnt", 32'(db_cnt), 32'd0);
      chk("clean_addr_wrap", 32'(addr), 32'd0);

      // Single-bit error at address 2: write-back of corrected data, then address 3
      inj_sb[2] = 1; inj_data[2] = 8'hA5;
      push_rd(0); push_rd(1); push_rd(2); push_wr(2, 8'hA5); push_rd(3);
      en = 1'b1;
      wait_pass();
      en = 1'b0;
      wait_idle();
      chk("sb_q_empty", 32'(exp_q.size()), 32'd0);
      chk("sb_cnt_one", 32'(sb_cnt), 32'd1);
      chk("sb_db_cnt", 32'(db_cnt), 32'd0);

      // Double- and single-bit flags together at address 1: double wins, no write
      inj_sb[1] = 1; inj_db[1] = 1; inj_data[1] = 8'h77;
      for (int a = 0; a < DEPTH; a++) push_rd(a);
      en = 1'b1;
      wait_pass();
      en = 1'b0;
      wait_idle();
      chk("db_q_empty", 32'(exp_q.size()), 32'd0);
      chk("db_cnt_one", 32'(db_cnt), 32'd1);
      chk("db_addr", 32'(db_addr), 32'd1);
      chk("db_irq_width", 32'(irq_cycles), 32'd1);
      chk("db_sb_unchanged", 32'(sb_cnt), 32'd1);

      // Grant withheld: request and address must hold steady
      gnt = 1'b0;
      push_rd(0);
      en = 1'b1;
      wait_req();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_req", 32'(req), 32'd1);
         chk("stall_addr", 32'(addr), 32'd0);
         chk("stall_we", 32'(we), 32'd0);
      end
      chk("stall_busy", 32'(busy), 32'd1);
      gnt = 1'b1;
      en  = 1'b0;
      wait_idle();
      chk("stall_q_empty", 32'(exp_q.size()), 32'd0);
      chk("stall_addr_next", 32'(addr), 32'd1);

      // Enable dropped while the read is outstanding: write-back still completes
      inj_sb[1] = 1; inj_data[1] = 8'h5A;
      push_rd(1); push_wr(1, 8'h5A);
      en = 1'b1;
      begin
         bit seen = 0;
         for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (req && gnt && !we) seen = 1;
         end
         chk("drop_rd_grant", 32'(seen), 32'd1);
      end
      @(negedge clk);
      en = 1'b0;
      wait_idle();
      chk("drop_busy", 32'(busy), 32'd0);
      chk("drop_req", 32'(req), 32'd0);
      chk("drop_q_empty", 32'(exp_q.size()), 32'd0);
      chk("drop_sb_cnt", 32'(sb_cnt), 32'd2);
      chk("drop_addr_next", 32'(addr), 32'd2);

      // Reset in the middle of an ungranted request
      gnt = 1'b0;
      en  = 1'b1;
      wait_req();
      rst = 1'b1;
      en  = 1'b0;
      @(negedge clk);
      chk("midrst_req", 32'(req), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_addr", 32'(addr), 32'd0);
      chk("midrst_sb_cnt", 32'(sb_cnt), 32'd0);
      chk("midrst_db_cnt", 32'(db_cnt), 32'd0);
      chk("midrst_db_addr", 32'(db_addr), 32'd0);
      rst = 1'b0;
      gnt = 1'b1;

      // Five corrected errors into a 2-bit counter: saturates at 3
      inj_sb[0] = 2;
      for (int a = 0; a < DEPTH; a++) begin
         if (a != 0) inj_sb[a] = 1;
         inj_data[a] = 8'hA0 | 8'(a);
      end
      for (int a = 0; a < DEPTH; a++) begin
         push_rd(a);
         push_wr(a, 8'hA0 | 8'(a));
      end
      push_rd(0); push_wr(0, 8'hA0);
      en = 1'b1;
      begin
         bit done = 0;
         for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) done = 1;
         end
         chk("sat_all_xfers", 32'(done), 32'd1);
      end
      en = 1'b0;
      wait_idle();
      chk("sat_sb_cnt", 32'(sb_cnt), 32'd3);
      chk("sat_db_cnt", 32'(db_cnt), 32'd0);
      chk("sat_q_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
